ppu_reg_if: RTL

CPU-bus responder for the picture-processing unit's eight memory-mapped registers ($2000-$2007, mirrored). It is the target side of the CPU's A/D/R_W_n bus: it decodes register accesses, holds control, mask, scroll and address state, and returns read data. It also runs a request/acknowledge handshake to PPU VRAM for $2007 traffic and drives the CPU NMI line.

---
 rtl/ppu_reg_if_pkg.sv | 23 ++
 rtl/ppu_vram_port.sv | 77 +++++++
 rtl/ppu_reg_if.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ppu_reg_if_pkg.sv
// Shared register offsets, VRAM port state encodings and sizing constants
// for the PPU CPU-bus register interface.
package ppu_reg_if_pkg;

  localparam logic [2:0] PPU_CTRL    = 3'd0;
  localparam logic [2:0] PPU_MASK    = 3'd1;
  localparam logic [2:0] PPU_STATUS  = 3'd2;
  localparam logic [2:0] PPU_OAMADDR = 3'd3;
  localparam logic [2:0] PPU_OAMDATA = 3'd4;
  localparam logic [2:0] PPU_SCROLL  = 3'd5;
  localparam logic [2:0] PPU_ADDR    = 3'd6;
  localparam logic [2:0] PPU_DATA    = 3'd7;

  localparam int PPU_VADDR_WIDTH = 14;
  localparam int PPU_INC_ROW     = 32;

  typedef enum logic [1:0] {
    PPU_VS_IDLE    = 2'd0,
    PPU_VS_WR_WAIT = 2'd1,
    PPU_VS_RD_WAIT = 2'd2
  } ppu_vs_e;

endpackage

// File: rtl/ppu_vram_port.sv
// Request/acknowledge port to PPU VRAM for $2007 traffic; owns the
// buffered read data returned on the next $2007 read.
//
// state          | meaning
// ---------------+------------------------------------------------
// PPU_VS_IDLE    | no request outstanding, new $2007 access accepted
// PPU_VS_WR_WAIT | write request held until vram_ack
// PPU_VS_RD_WAIT | read request held; read_buf loads on vram_ack
module ppu_vram_port
  import ppu_reg_if_pkg::*;
#(
  parameter int VADDR_WIDTH = PPU_VADDR_WIDTH,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   we,
  input  logic [VADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0]  wdata_in,
  input  logic                   vram_ack,
  input  logic [DATA_WIDTH-1:0]  vram_rdata,
  output logic [VADDR_WIDTH-1:0] vram_addr,
  output logic [DATA_WIDTH-1:0]  vram_wdata,
  output logic                   vram_we,
  output logic                   vram_req,
  output logic [DATA_WIDTH-1:0]  read_buf,
  output logic                   idle
);

  ppu_vs_e state;

  assign idle = (state == PPU_VS_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= PPU_VS_IDLE;
      vram_addr  <= '0;
      vram_wdata <= '0;
      vram_we    <= 1'b0;
      vram_req   <= 1'b0;
      read_buf   <= '0;
    end else begin
      case (state)
        PPU_VS_IDLE: begin
          // a stray ack here is deliberately ignored
          if (start) begin
            vram_addr <= addr_in;
            vram_we   <= we;
            vram_req  <= 1'b1;
            if (we) begin
              vram_wdata <= wdata_in;
              state      <= PPU_VS_WR_WAIT;
            end else begin
              state <= PPU_VS_RD_WAIT;
            end
          end
        end
        PPU_VS_WR_WAIT: begin
          if (vram_ack) begin
            vram_req <= 1'b0;
            state    <= PPU_VS_IDLE;
          end
        end
        PPU_VS_RD_WAIT: begin
          if (vram_ack) begin
            read_buf <= vram_rdata;
            vram_req <= 1'b0;
            state    <= PPU_VS_IDLE;
          end
        end
        default: state <= PPU_VS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ppu_reg_if.sv
// CPU-bus responder for the eight PPU registers: decode, scroll/address
// latches (w, t, v), status/vblank/NMI and registered read return.
module ppu_reg_if
  import ppu_reg_if_pkg::*;
#(
  parameter int VADDR_WIDTH = PPU_VADDR_WIDTH,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cs_n,
  input  logic [2:0]             addr,
  input  logic                   r_w_n,
  input  logic [DATA_WIDTH-1:0]  d_in,
  output logic [DATA_WIDTH-1:0]  d_out,
  output logic                   d_oe,
  output logic [DATA_WIDTH-1:0]  ctrl,
  output logic [DATA_WIDTH-1:0]  mask,
  output logic [DATA_WIDTH-1:0]  scroll_x,
  output logic [DATA_WIDTH-1:0]  scroll_y,
  output logic [DATA_WIDTH-1:0]  oam_addr,
  output logic [DATA_WIDTH-1:0]  oam_wdata,
  output logic                   oam_we,
  input  logic [DATA_WIDTH-1:0]  oam_rdata,
  input  logic                   vblank_set,
  input  logic                   vblank_clr,
  input  logic                   spr0_hit,
  input  logic                   spr_ovf,
  output logic [VADDR_WIDTH-1:0] vram_addr,
  output logic [DATA_WIDTH-1:0]  vram_wdata,
  output logic                   vram_we,
  output logic                   vram_req,
  input  logic                   vram_ack,
  input  logic [DATA_WIDTH-1:0]  vram_rdata,
  output logic                   nmi_n
);

  logic [VADDR_WIDTH-1:0] t, v, t_nxt, v_nxt, v_inc;
  logic                   w, w_nxt;
  logic [DATA_WIDTH-1:0]  io_latch, read_buf, rd_data, ctrl_nxt;
  logic                   vblank, vblank_nxt;
  logic                   acc_rd, acc_wr, status_rd, vram_idle, vram_start;

  assign acc_rd     = !cs_n && r_w_n;
  assign acc_wr     = !cs_n && !r_w_n;
  assign status_rd  = acc_rd && (addr == PPU_STATUS);
  // $2007 traffic arriving while a request is outstanding is dropped
  assign vram_start = !cs_n && (addr == PPU_DATA) && vram_idle;
  assign v_inc      = ctrl[2] ? VADDR_WIDTH'(PPU_INC_ROW) : VADDR_WIDTH'(1);
  assign ctrl_nxt   = (acc_wr && addr == PPU_CTRL) ? d_in : ctrl;

  always_comb begin
    rd_data = io_latch;
    case (addr)
      // vblank_set landing on the status read is suppressed
      PPU_STATUS:  rd_data = {vblank & ~vblank_set, spr0_hit, spr_ovf, io_latch[4:0]};
      PPU_OAMDATA: rd_data = oam_rdata;
      PPU_DATA:    rd_data = read_buf;
      default:     rd_data = io_latch;
    endcase
  end

  always_comb begin
    vblank_nxt = vblank;
    if (vblank_set) vblank_nxt = 1'b1;
    if (status_rd)  vblank_nxt = 1'b0;
    if (vblank_clr) vblank_nxt = 1'b0;
  end

  always_comb begin
    t_nxt = t;
    v_nxt = v;
    w_nxt = w;
    if (status_rd) w_nxt = 1'b0;
    if (acc_wr) begin
      case (addr)
        PPU_CTRL:   t_nxt[11:10] = d_in[1:0];
        PPU_SCROLL: w_nxt = ~w;
        PPU_ADDR: begin
          if (!w) begin
            t_nxt       = '0;
            t_nxt[7:0]  = t[7:0];
            t_nxt[13:8] = d_in[5:0];
            w_nxt       = 1'b1;
          end else begin
            t_nxt[7:0] = d_in;
            v_nxt      = t_nxt;
            w_nxt      = 1'b0;
          end
        end
        default: ;
      endcase
    end
    if (vram_start) v_nxt = v + v_inc;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl      <= '0;
      mask      <= '0;
      scroll_x  <= '0;
      scroll_y  <= '0;
      oam_addr  <= '0;
      oam_wdata <= '0;
      oam_we    <= 1'b0;
      d_out     <= '0;
      d_oe      <= 1'b0;
      io_latch  <= '0;
      vblank    <= 1'b0;
      t         <= '0;
      v         <= '0;
      w         <= 1'b0;
      nmi_n     <= 1'b1;
    end else begin
      ctrl   <= ctrl_nxt;
      vblank <= vblank_nxt;
      t      <= t_nxt;
      v      <= v_nxt;
      w      <= w_nxt;
      nmi_n  <= ~(vblank_nxt & ctrl_nxt[7]);
      oam_we <= acc_wr && (addr == PPU_OAMDATA);
      d_oe   <= acc_rd;
      if (acc_rd) begin
        d_out    <= rd_data;
        io_latch <= rd_data;
      end
      if (acc_wr) begin
        io_latch <= d_in;
        case (addr)
          PPU_MASK:    mask <= d_in;
          PPU_OAMADDR: oam_addr <= d_in;
          PPU_OAMDATA: begin
            oam_wdata <= d_in;
            oam_addr  <= oam_addr + DATA_WIDTH'(1);
          end
          PPU_SCROLL: begin
            if (!w) scroll_x <= d_in;
            else    scroll_y <= d_in;
          end
          default: ;
        endcase
      end
    end
  end

  ppu_vram_port #(
    .VADDR_WIDTH(VADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_vram_port (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (vram_start),
    .we        (!r_w_n),
    .addr_in   (v),
    .wdata_in  (d_in),
    .vram_ack  (vram_ack),
    .vram_rdata(vram_rdata),
    .vram_addr (vram_addr),
    .vram_wdata(vram_wdata),
    .vram_we   (vram_we),
    .vram_req  (vram_req),
    .read_buf  (read_buf),
    .idle      (vram_idle)
  );

endmodule
